// File: rtl/tone_direction_decoder.sv
// Tone-detection front end: integrates five band-pass comparator lines over fixed
// windows and debounces the per-window direction candidate into tdEn / tdDir.
module tone_direction_decoder #(
  parameter int WINDOW_CYCLES   = 500_000,
  parameter int ACTIVE_THRESH   = 250_000,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int RELEASE_WINDOWS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic [4:0] chanActive
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int HIT_W = $clog2(WINDOW_CYCLES + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [HIT_W-1:0] HIT_MAX  = '1;
  localparam logic [HIT_W:0]   THRESH   = (HIT_W + 1)'(ACTIVE_THRESH);
  localparam logic [3:0]       CONF_N   = 4'(CONFIRM_WINDOWS);
  localparam logic [3:0]       REL_N    = 4'(RELEASE_WINDOWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2,
    RELEASE = 2'd3
  } stateT;

  logic [4:0]       bpRaw;
  logic [4:0]       bpMeta;
  logic [4:0]       bpSync;
  logic [WIN_W-1:0] winCnt;
  logic             winLast;
  logic             evalStrobe;
  logic [HIT_W-1:0] hits     [5];
  logic [HIT_W:0]   hitTotal [5];

  logic             candValid;
  logic [1:0]       candCode;

  stateT            state,     stateNext;
  logic [1:0]       candDir,   candDirNext;
  logic [3:0]       confCnt,   confCntNext;
  logic [3:0]       relCnt,    relCntNext;
  logic             tdEnNext;
  logic [1:0]       tdDirNext;

  assign bpRaw   = {bp5, bp4, bp3, bp2, bp1};
  assign winLast = (winCnt == WIN_LAST);

  // The closing cycle's own sample still belongs to the window being evaluated.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      hitTotal[i] = {1'b0, hits[i]} + (HIT_W + 1)'(bpSync[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would turn the 2-flop synchroniser into one flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bpMeta     <= '0;
      bpSync     <= '0;
      winCnt     <= '0;
      evalStrobe <= 1'b0;
      chanActive <= '0;
      for (int i = 0; i < 5; i++) hits[i] <= '0;
    end else begin
      bpMeta     <= bpRaw;
      bpSync     <= bpMeta;
      evalStrobe <= winLast;
      winCnt     <= winLast ? '0 : winCnt + WIN_W'(1);
      for (int i = 0; i < 5; i++) begin
        if (winLast) begin
          chanActive[i] <= (hitTotal[i] >= THRESH);
          hits[i]       <= '0;
        end else if (bpSync[i] && (hits[i] != HIT_MAX)) begin
          hits[i] <= hits[i] + HIT_W'(1);
        end
      end
    end
  end

  // A window is a command only when exactly one command band fired and the
  // guard band stayed quiet; broadband noise lights bp5 and vetoes everything.
  always_comb begin
    candValid = 1'b0;
    candCode  = 2'b00;
    unique case (chanActive)
      5'b00001: begin candValid = 1'b1; candCode = 2'b00; end
      5'b00010: begin candValid = 1'b1; candCode = 2'b01; end
      5'b00100: begin candValid = 1'b1; candCode = 2'b10; end
      5'b01000: begin candValid = 1'b1; candCode = 2'b11; end
      default:  begin candValid = 1'b0; candCode = 2'b00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      candDir <= 2'b00;
      confCnt <= '0;
      relCnt  <= '0;
      tdEn    <= 1'b0;
      tdDir   <= 2'b00;
    end else begin
      state   <= stateNext;
      candDir <= candDirNext;
      confCnt <= confCntNext;
      relCnt  <= relCntNext;
      tdEn    <= tdEnNext;
      tdDir   <= tdDirNext;
    end
  end

  // NOTE: every next-state variable is defaulted to its current value first, so
  // paths that do not assign it hold state instead of inferring a latch.
  always_comb begin
    stateNext   = state;
    candDirNext = candDir;
    confCntNext = confCnt;
    relCntNext  = relCnt;
    tdEnNext    = tdEn;
    tdDirNext   = tdDir;

    if (evalStrobe) begin
      unique case (state)
        IDLE: begin
          if (candValid) begin
            candDirNext = candCode;
            confCntNext = 4'd1;
            if (CONF_N == 4'd1) begin
              stateNext = LOCKED;
              tdEnNext  = 1'b1;
              tdDirNext = candCode;
            end else begin
              stateNext = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (!candValid) begin
            stateNext = IDLE;
          end else if (candCode == candDir) begin
            confCntNext = confCnt + 4'd1;
            if (confCnt + 4'd1 == CONF_N) begin
              stateNext = LOCKED;
              tdEnNext  = 1'b1;
              tdDirNext = candDir;
            end
          end else begin
            candDirNext = candCode;
            confCntNext = 4'd1;
          end
        end
        LOCKED: begin
          if (candValid && (candCode == candDir)) begin
            relCntNext = '0;
          end else begin
            relCntNext = 4'd1;
            if (REL_N == 4'd1) begin
              stateNext = IDLE;
              tdEnNext  = 1'b0;
            end else begin
              stateNext = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (candValid && (candCode == candDir)) begin
            stateNext  = LOCKED;
            relCntNext = '0;
          end else begin
            relCntNext = relCnt + 4'd1;
            if (relCnt + 4'd1 == REL_N) begin
              stateNext = IDLE;
              tdEnNext  = 1'b0;
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

endmodule
